// File: rtl/button_stepper_pkg.sv
// rtl/button_stepper_pkg.sv - shared state encoding and direction constants for the button stepper
package button_stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCKED = 2'd3
    } step_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser plus stability counter producing a clean button level
module button_debounce #(
    parameter int DEBOUNCE_CNT = 500000,
    parameter int CNT_WIDTH    = 26
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic lvl_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CNT - 1);

    logic [1:0]           sync_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 lvl_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            // Any cycle agreeing with the current level restarts the stability count.
            if (sync_q[1] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= CNT_LAST) begin
                cnt_q <= '0;
                lvl_q <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign lvl_o = lvl_q;

endmodule

// File: rtl/button_stepper.sv
// rtl/button_stepper.sv - debounced hold-to-repeat step strobe generator for the LED ruler
module button_stepper
    import button_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int CNT_WIDTH    = 26
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_left_i,
    input  logic btn_right_i,
    output logic stb_o,
    output logic dir_o,
    output logic busy_o
);

    localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RATE_LAST  = CNT_WIDTH'(REPEAT_RATE - 1);

    logic lvl_l;
    logic lvl_r;

    button_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_deb_left (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .btn_i (btn_left_i),
        .lvl_o (lvl_l)
    );

    button_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_deb_right (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .btn_i (btn_right_i),
        .lvl_o (lvl_r)
    );

    step_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 stb_q, stb_d;
    logic                 dir_q, dir_d;
    logic                 active_lvl;
    logic                 other_lvl;
    logic [CNT_WIDTH-1:0] cnt_limit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            dir_q   <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stb_d      = 1'b0;
        dir_d      = dir_q;
        active_lvl = (dir_q == DIR_RIGHT) ? lvl_r : lvl_l;
        other_lvl  = (dir_q == DIR_RIGHT) ? lvl_l : lvl_r;
        cnt_limit  = (state_q == ST_DELAY) ? DELAY_LAST : RATE_LAST;

        case (state_q)
            ST_IDLE: begin
                if (lvl_l && lvl_r) begin
                    state_d = ST_LOCKED;
                end else if (lvl_l || lvl_r) begin
                    state_d = ST_DELAY;
                    stb_d   = 1'b1;
                    dir_d   = lvl_r ? DIR_RIGHT : DIR_LEFT;
                    cnt_d   = '0;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                // The other button locks out stepping even if the active one lets go this cycle.
                if (other_lvl) begin
                    state_d = ST_LOCKED;
                end else if (!active_lvl) begin
                    state_d = ST_IDLE;
                end else if ((cnt_q >= cnt_limit) && !stb_q) begin
                    // Holding off while stb_q is high keeps strobes at least two cycles apart.
                    state_d = ST_REPEAT;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (!lvl_l && !lvl_r) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign stb_o  = stb_q;
    assign dir_o  = dir_q;
    assign busy_o = lvl_l | lvl_r;

endmodule

// File: tb/tb_button_stepper.sv
// tb/tb_button_stepper.sv - directed self-checking bench for button_stepper
module tb_button_stepper;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_l;
    logic btn_r;
    logic stb;
    logic dir;
    logic busy;

    button_stepper #(
        .DEBOUNCE_CNT(4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE (8),
        .CNT_WIDTH   (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .btn_left_i (btn_l),
        .btn_right_i(btn_r),
        .stb_o      (stb),
        .dir_o      (dir),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   consec = 0;
    int   t0;
    logic prev_stb = 1'b0;
    int   stb_times[$];
    logic stb_dirs[$];
    int   rep_exp[6] = '{7, 27, 35, 43, 51, 59};

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (stb) begin
                stb_times.push_back(cyc);
                stb_dirs.push_back(dir);
                if (prev_stb) consec++;
            end
            prev_stb = stb;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        btn_l = 1'b0;
        btn_r = 1'b0;
        tick(3);
        chk("reset_stb", 32'(stb), 32'd0);
        chk("reset_dir", 32'(dir), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single press on the right button
        stb_times.delete();
        stb_dirs.delete();
        btn_r = 1'b1;
        tick(6);
        chk("single_no_early_stb", 32'(stb), 32'd0);
        chk("single_busy_rise", 32'(busy), 32'd1);
        tick(1);
        chk("single_stb", 32'(stb), 32'd1);
        chk("single_dir", 32'(dir), 32'd1);
        tick(3);
        btn_r = 1'b0;
        tick(5);
        chk("single_busy_held", 32'(busy), 32'd1);
        tick(1);
        chk("single_busy_drop", 32'(busy), 32'd0);
        tick(20);
        chk("single_stb_count", 32'(stb_times.size()), 32'd1);

        // Bouncing left button, then a stable press
        stb_times.delete();
        stb_dirs.delete();
        for (int i = 0; i < 10; i++) begin
            btn_l = ~btn_l;
            tick(3);
        end
        tick(8);
        chk("bounce_no_stb", 32'(stb_times.size()), 32'd0);
        chk("bounce_busy", 32'(busy), 32'd0);
        btn_l = 1'b1;
        tick(6);
        chk("bounce_no_early_stb", 32'(stb), 32'd0);
        tick(1);
        chk("bounce_stb", 32'(stb), 32'd1);
        chk("bounce_dir", 32'(dir), 32'd0);
        btn_l = 1'b0;
        tick(12);
        chk("bounce_stb_count", 32'(stb_times.size()), 32'd1);

        // Auto-repeat while holding right
        stb_times.delete();
        stb_dirs.delete();
        t0 = cyc;
        btn_r = 1'b1;
        tick(60);
        btn_r = 1'b0;
        tick(30);
        chk("repeat_count", 32'(stb_times.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("repeat_time_%0d", k),
                (k < stb_times.size()) ? 32'(stb_times[k] - t0) : 32'hFFFF_FFFF,
                32'(rep_exp[k]));
            chk($sformatf("repeat_dir_%0d", k),
                (k < stb_dirs.size()) ? 32'(stb_dirs[k]) : 32'hFFFF_FFFF, 32'd1);
        end

        // Lock: left then right, release right, then left, then press left again
        stb_times.delete();
        stb_dirs.delete();
        btn_l = 1'b1;
        tick(5);
        btn_r = 1'b1;
        tick(40);
        chk("lock_one_stb", 32'(stb_times.size()), 32'd1);
        chk("lock_stb_dir", (stb_dirs.size() > 0) ? 32'(stb_dirs[0]) : 32'hFFFF_FFFF, 32'd0);
        btn_r = 1'b0;
        tick(15);
        chk("lock_right_release", 32'(stb_times.size()), 32'd1);
        chk("lock_busy_left", 32'(busy), 32'd1);
        btn_l = 1'b0;
        tick(10);
        chk("lock_busy_clear", 32'(busy), 32'd0);
        chk("lock_after_release", 32'(stb_times.size()), 32'd1);
        btn_l = 1'b1;
        tick(7);
        chk("lock_fresh_stb", 32'(stb), 32'd1);
        chk("lock_fresh_dir", 32'(dir), 32'd0);
        btn_l = 1'b0;
        tick(12);
        chk("lock_total", 32'(stb_times.size()), 32'd2);

        // Simultaneous press
        stb_times.delete();
        stb_dirs.delete();
        btn_l = 1'b1;
        btn_r = 1'b1;
        tick(30);
        chk("simul_no_stb", 32'(stb_times.size()), 32'd0);
        chk("simul_busy", 32'(busy), 32'd1);
        btn_l = 1'b0;
        btn_r = 1'b0;
        tick(5);
        chk("simul_busy_held", 32'(busy), 32'd1);
        tick(1);
        chk("simul_busy_drop", 32'(busy), 32'd0);
        tick(10);
        chk("simul_no_stb_end", 32'(stb_times.size()), 32'd0);

        // Reset in the middle of DELAY with right held
        btn_r = 1'b1;
        tick(10);
        chk("prereset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_stb", 32'(stb), 32'd0);
        chk("midreset_dir", 32'(dir), 32'd1);
        chk("midreset_busy", 32'(busy), 32'd0);
        tick(2);
        stb_times.delete();
        stb_dirs.delete();
        rst_n = 1'b1;
        tick(6);
        chk("postreset_no_early_stb", 32'(stb), 32'd0);
        tick(1);
        chk("postreset_stb", 32'(stb), 32'd1);
        chk("postreset_dir", 32'(dir), 32'd1);
        btn_r = 1'b0;
        tick(12);
        chk("postreset_stb_count", 32'(stb_times.size()), 32'd1);

        chk("no_back_to_back", 32'(consec), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
